// File: rtl/seg7_blink_multi.sv
// Multi-digit 7-segment driver with a per-digit blink mask and force-off.
// Segment outputs are registered and low-active (gfedcba per digit).
module seg7_blink_multi #(
    parameter int NDIG  = 4,
    parameter int DIV   = 25000000,
    parameter int DIV_W = 25
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 en,
    input  logic                 ld,
    input  logic [5*NDIG-1:0]    code,
    input  logic [NDIG-1:0]      blank,
    input  logic [NDIG-1:0]      bmask,
    output logic [7*NDIG-1:0]    nSEG,
    output logic                 phase,
    output logic                 tick
);

    localparam logic [DIV_W-1:0] LAST_CNT = DIV_W'(DIV - 1);

    logic [DIV_W-1:0]  cnt;
    logic [5*NDIG-1:0] shadowCode;
    logic [NDIG-1:0]   shadowBlank;
    logic [NDIG-1:0]   shadowBmask;
    logic [7*NDIG-1:0] segNext;

    function automatic logic [6:0] decodeChar(input logic [4:0] c);
        logic [6:0] seg;
        case (c)
            5'h00: seg = 7'h40;
            5'h01: seg = 7'h79;
            5'h02: seg = 7'h24;
            5'h03: seg = 7'h30;
            5'h04: seg = 7'h19;
            5'h05: seg = 7'h12;
            5'h06: seg = 7'h02;
            5'h07: seg = 7'h78;
            5'h08: seg = 7'h00;
            5'h09: seg = 7'h10;
            5'h0A: seg = 7'h08;
            5'h0B: seg = 7'h03;
            5'h0C: seg = 7'h46;
            5'h0D: seg = 7'h21;
            5'h0E: seg = 7'h06;
            5'h0F: seg = 7'h0E;
            5'h10: seg = 7'h47;
            5'h11: seg = 7'h3F;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    // Dropping the enable parks the blinker in its visible half with a fresh period.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt   <= '0;
            phase <= 1'b1;
            tick  <= 1'b0;
        end else if (!en) begin
            cnt   <= '0;
            phase <= 1'b1;
            tick  <= 1'b0;
        end else if (cnt == LAST_CNT) begin
            cnt   <= '0;
            phase <= ~phase;
            tick  <= 1'b1;
        end else begin
            cnt   <= cnt + DIV_W'(1);
            tick  <= 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shadowCode  <= '0;
            shadowBlank <= '1;
            shadowBmask <= '0;
        end else if (ld) begin
            shadowCode  <= code;
            shadowBlank <= blank;
            shadowBmask <= bmask;
        end
    end

    // Force-off wins over everything; blink-masked digits go dark in the dark half.
    always_comb begin
        segNext = '1;
        for (int i = 0; i < NDIG; i++) begin
            if (shadowBlank[i] || (shadowBmask[i] && !phase))
                segNext[7*i +: 7] = 7'h7F;
            else
                segNext[7*i +: 7] = decodeChar(shadowCode[5*i +: 5]);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            nSEG <= '1;
        else
            nSEG <= segNext;
    end

endmodule

// File: tb/tb_seg7_blink_multi.sv
// Self-checking bench for seg7_blink_multi (NDIG=2, DIV=4): directed scenarios
// followed by randomized traffic compared against a run-length reference model.
module tb_seg7_blink_multi;

    localparam int NDIG = 2;
    localparam int DIV  = 4;

    logic              CLK;
    logic              RST;
    logic              en;
    logic              ld;
    logic [5*NDIG-1:0] code;
    logic [NDIG-1:0]   blank;
    logic [NDIG-1:0]   bmask;
    logic [7*NDIG-1:0] nSEG;
    logic              phase;
    logic              tick;

    int vectors;
    int miscompares;

    logic [6:0]        segTab [32];
    int                runLen;
    logic [5*NDIG-1:0] mCode;
    logic [NDIG-1:0]   mBlank;
    logic [NDIG-1:0]   mBmask;
    logic [7*NDIG-1:0] expSeg;
    logic              expTick;

    seg7_blink_multi #(.NDIG(NDIG), .DIV(DIV), .DIV_W(3)) dut (
        .CLK(CLK), .RST(RST), .en(en), .ld(ld), .code(code),
        .blank(blank), .bmask(bmask), .nSEG(nSEG), .phase(phase), .tick(tick)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Blink phase derived from how many consecutive enabled cycles have elapsed.
    function automatic logic phaseOf(input int n);
        return ((n / DIV) % 2) == 0;
    endfunction

    function automatic logic [7*NDIG-1:0] showDigits();
        logic [7*NDIG-1:0] s;
        for (int i = 0; i < NDIG; i++) begin
            if (mBlank[i] || (mBmask[i] && !phaseOf(runLen)))
                s[7*i +: 7] = 7'h7F;
            else
                s[7*i +: 7] = segTab[mCode[5*i +: 5]];
        end
        return s;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        runLen  = 0;
        mCode   = '0;
        mBlank  = '1;
        mBmask  = '0;
        expSeg  = '1;
        expTick = 1'b0;
    endtask

    task automatic stepCycle();
        @(posedge CLK);
        if (RST) begin
            modelReset();
        end else begin
            expSeg = showDigits();
            if (ld) begin
                mCode  = code;
                mBlank = blank;
                mBmask = bmask;
            end
            if (en) runLen++;
            else    runLen = 0;
            expTick = en && (runLen % DIV == 0);
        end
        #1;
        checkOutput("nSEG", 32'(nSEG), 32'(expSeg));
        checkOutput("phase", 32'(phase), 32'(phaseOf(runLen)));
        checkOutput("tick", 32'(tick), 32'(expTick));
    endtask

    task automatic applyStimulus(input logic e, input logic l, input logic [5*NDIG-1:0] c,
                                 input logic [NDIG-1:0] b, input logic [NDIG-1:0] m);
        en    = e;
        ld    = l;
        code  = c;
        blank = b;
        bmask = m;
        stepCycle();
    endtask

    task automatic pulseReset();
        RST = 1'b1;
        #1;
        checkOutput("rstSeg", 32'(nSEG), 32'h3FFF);
        checkOutput("rstPhase", 32'(phase), 32'd1);
        checkOutput("rstTick", 32'(tick), 32'd0);
        modelReset();
    endtask

    initial begin
        logic [6:0] tab [17];
        vectors     = 0;
        miscompares = 0;
        tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E, 7'h47};
        for (int i = 0; i < 32; i++) segTab[i] = (i < 17) ? tab[i] : 7'h7F;
        segTab[17] = 7'h3F;

        RST = 1'b0; en = 1'b0; ld = 1'b0; code = '0; blank = '0; bmask = '0;
        #2;
        pulseReset();

        // Load attempted while reset is held must be ignored.
        applyStimulus(1'b0, 1'b1, {5'h01, 5'h02}, 2'b00, 2'b00);
        RST = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, 2'b00, 2'b00);
        checkOutput("ldInReset", 32'(nSEG), 32'h3FFF);

        // Steady "L3" with blinking disabled.
        applyStimulus(1'b0, 1'b1, {5'h10, 5'h03}, 2'b00, 2'b00);
        applyStimulus(1'b0, 1'b0, '0, 2'b00, 2'b00);
        checkOutput("loadL3", 32'(nSEG), 32'({7'h47, 7'h30}));
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, '0, 2'b00, 2'b00);

        // Blink digit 1 only.
        applyStimulus(1'b0, 1'b1, {5'h10, 5'h03}, 2'b00, 2'b10);
        for (int i = 0; i < 18; i++) applyStimulus(1'b1, 1'b0, '0, 2'b00, 2'b00);
        checkOutput("steadyDig0", 32'(nSEG[6:0]), 32'h30);

        // Drop enable two cycles into a period, then re-raise.
        while (runLen % DIV != 2) applyStimulus(1'b1, 1'b0, '0, 2'b00, 2'b00);
        applyStimulus(1'b0, 1'b0, '0, 2'b00, 2'b00);
        checkOutput("dropPhase", 32'(phase), 32'd1);
        checkOutput("dropTick", 32'(tick), 32'd0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, '0, 2'b00, 2'b00);
        checkOutput("reraiseTick", 32'(tick), 32'd1);
        checkOutput("reraisePhase", 32'(phase), 32'd0);

        // Load coinciding with a wrap: new characters and new phase together.
        while (runLen % DIV != DIV - 1) applyStimulus(1'b1, 1'b0, '0, 2'b00, 2'b00);
        applyStimulus(1'b1, 1'b1, {5'h0A, 5'h05}, 2'b00, 2'b10);
        applyStimulus(1'b1, 1'b0, '0, 2'b00, 2'b00);
        checkOutput("wrapLoadDig0", 32'(nSEG[6:0]), 32'h12);

        // Force-off and undefined codes.
        applyStimulus(1'b0, 1'b1, {5'h15, 5'h08}, 2'b01, 2'b00);
        applyStimulus(1'b0, 1'b0, '0, 2'b00, 2'b00);
        checkOutput("blankDigits", 32'(nSEG), 32'h3FFF);
        applyStimulus(1'b0, 1'b1, {5'h11, 5'h0F}, 2'b00, 2'b00);
        applyStimulus(1'b0, 1'b0, '0, 2'b00, 2'b00);
        checkOutput("dashF", 32'(nSEG), 32'({7'h3F, 7'h0E}));

        // Randomized traffic with occasional asynchronous resets.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                pulseReset();
                applyStimulus(1'b1, 1'b1, 10'($urandom), 2'($urandom), 2'($urandom));
                RST = 1'b0;
            end
            applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0, 10'($urandom),
                          2'($urandom_range(0, 3) == 0), 2'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
